// File: rtl/data_seq_pkg.sv
// Shared types and helpers for the data access sequencer: FSM states, access-size
// encodings and the byte-mask helper used by both the top and the lane aligner.
package data_seq_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACC_LO = 2'd1,
        ACC_HI = 2'd2,
        FINISH = 2'd3
    } seq_state_t;

    localparam logic [1:0] FMT_BYTE    = 2'b00;
    localparam logic [1:0] FMT_HALF    = 2'b01;
    localparam logic [1:0] FMT_WORD    = 2'b10;
    localparam logic [1:0] FMT_ILLEGAL = 2'b11;

    // Illegal format maps to a full mask; such requests are faulted before use.
    function automatic logic [3:0] size_mask(input logic [1:0] fmt);
        case (fmt)
            FMT_BYTE: size_mask = 4'b0001;
            FMT_HALF: size_mask = 4'b0011;
            default:  size_mask = 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/data_lane_align.sv
// Combinational lane steering: byte enables and write data for the low/high words of
// an access, plus 64->32 read realignment with sign/zero extension.
module data_lane_align
    import data_seq_pkg::*;
(
    input  logic [1:0]  i_off,
    input  logic [2:0]  i_format,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_lo_word,
    input  logic [31:0] i_hi_word,
    output logic [3:0]  o_be_lo,
    output logic [3:0]  o_be_hi,
    output logic [31:0] o_data_lo,
    output logic [31:0] o_data_hi,
    output logic [31:0] o_rdata
);

    logic [7:0]  w_be;
    logic [63:0] w_wlanes;
    logic [31:0] w_rshift;

    always_comb begin
        // Shifting across a 64-bit span yields both halves of a straddling access at once.
        w_be     = 8'({4'b0000, size_mask(i_format[1:0])} << i_off);
        w_wlanes = {32'b0, i_wdata} << {i_off, 3'b000};
        w_rshift = 32'({i_hi_word, i_lo_word} >> {i_off, 3'b000});

        o_be_lo   = w_be[3:0];
        o_be_hi   = w_be[7:4];
        o_data_lo = w_wlanes[31:0];
        o_data_hi = w_wlanes[63:32];

        case (i_format[1:0])
            FMT_BYTE: o_rdata = {{24{~i_format[2] & w_rshift[7]}}, w_rshift[7:0]};
            FMT_HALF: o_rdata = {{16{~i_format[2] & w_rshift[15]}}, w_rshift[15:0]};
            default:  o_rdata = w_rshift;
        endcase
    end

endmodule

// File: rtl/data_access_sequencer.sv
// Sequences LSU load/store requests onto a single-ported word memory, splitting
// word-straddling accesses in two when DATA_MISALIGNED_SPLIT_EN is defined.
module data_access_sequencer
    import data_seq_pkg::*;
#(
    parameter int          ADDR_WIDTH = 15,
    parameter logic [31:0] DATA_BEGIN = 32'h1001_0000,
    parameter logic [31:0] DATA_END   = 32'h1001_FFFF
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [2:0]            req_format,
    input  logic [31:0]           req_address,
    input  logic [31:0]           req_wdata,
    output logic                  resp_valid,
    output logic                  resp_error,
    output logic [31:0]           resp_rdata,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [3:0]            mem_byteena,
    output logic [31:0]           mem_data,
    output logic                  mem_wren,
    input  logic [31:0]           mem_q
);

    seq_state_t            r_state;
    seq_state_t            w_state_next;
    logic                  r_write;
    logic [2:0]            r_format;
    logic [1:0]            r_off;
    logic [ADDR_WIDTH-1:0] r_word;
    logic [31:0]           r_wdata;
    logic [31:0]           r_lo;
    logic                  r_cross;
    logic                  r_err;

    logic        w_accept;
    logic        w_cross;
    logic        w_err_range;
    logic        w_fault;
    logic [7:0]  w_be_req;
    logic [1:0]  w_span;
    logic [32:0] w_last;
    logic        w_in_lo;
    logic        w_in_hi;
    logic [3:0]  w_be_lo;
    logic [3:0]  w_be_hi;
    logic [31:0] w_data_lo;
    logic [31:0] w_data_hi;
    logic [31:0] w_lo_word;
    logic [31:0] w_rdata;

    assign req_ready = (r_state == IDLE) && !reset;
    assign w_accept  = req_valid && req_ready;

    // Fault and crossing decisions are made on the live request in the accept cycle.
    always_comb begin
        w_be_req = 8'({4'b0000, size_mask(req_format[1:0])} << req_address[1:0]);
        w_cross  = |w_be_req[7:4];
        case (req_format[1:0])
            FMT_HALF: w_span = 2'd1;
            FMT_WORD: w_span = 2'd3;
            default:  w_span = 2'd0;
        endcase
        w_last      = {1'b0, req_address} + {31'b0, w_span};
        w_err_range = (req_format[1:0] == FMT_ILLEGAL) ||
                      (req_address < DATA_BEGIN) ||
                      (w_last > {1'b0, DATA_END});
`ifdef DATA_MISALIGNED_SPLIT_EN
        w_fault = w_err_range;
`else
        w_fault = w_err_range || w_cross;
`endif
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:   if (w_accept) w_state_next = w_fault ? FINISH : ACC_LO;
`ifdef DATA_MISALIGNED_SPLIT_EN
            ACC_LO: w_state_next = r_cross ? ACC_HI : FINISH;
`else
            ACC_LO: w_state_next = FINISH;
`endif
            ACC_HI: w_state_next = FINISH;
            FINISH: w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state  <= IDLE;
            r_lo     <= '0;
            r_write  <= 1'b0;
            r_format <= '0;
            r_off    <= '0;
            r_word   <= '0;
            r_wdata  <= '0;
            r_cross  <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_write  <= req_write;
                r_format <= req_format;
                r_off    <= req_address[1:0];
                r_word   <= req_address[ADDR_WIDTH+1:2];
                r_wdata  <= req_wdata;
                r_cross  <= w_cross;
                r_err    <= w_fault;
            end
            // mem_q during ACC_HI still carries the low word fetched in ACC_LO.
            if (r_state == ACC_HI) r_lo <= mem_q;
        end
    end

    assign w_lo_word = r_cross ? r_lo : mem_q;

    data_lane_align u_lane_align (
        .i_off     (r_off),
        .i_format  (r_format),
        .i_wdata   (r_wdata),
        .i_lo_word (w_lo_word),
        .i_hi_word (mem_q),
        .o_be_lo   (w_be_lo),
        .o_be_hi   (w_be_hi),
        .o_data_lo (w_data_lo),
        .o_data_hi (w_data_hi),
        .o_rdata   (w_rdata)
    );

    assign w_in_lo = (r_state == ACC_LO);
    assign w_in_hi = (r_state == ACC_HI);

    always_comb begin
        mem_address = r_word + {{(ADDR_WIDTH-1){1'b0}}, w_in_hi};
        mem_data    = w_in_hi ? w_data_hi : w_data_lo;
        mem_byteena = 4'b0000;
        if (!reset && w_in_lo) mem_byteena = w_be_lo;
        if (!reset && w_in_hi) mem_byteena = w_be_hi;
        mem_wren    = !reset && r_write && (w_in_lo || w_in_hi);
        resp_valid  = !reset && (r_state == FINISH);
        resp_error  = resp_valid && r_err;
        resp_rdata  = (resp_valid && !r_err && !r_write) ? w_rdata : 32'h0;
    end

endmodule

// File: tb/tb_data_access_sequencer.sv
// Directed bench for data_access_sequencer with a registered-read word memory model;
// crossing-access expectations follow whether DATA_MISALIGNED_SPLIT_EN is defined.
module tb_data_access_sequencer;
    import data_seq_pkg::*;

    localparam int AW = 15;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_write = 1'b0;
    logic [2:0]    req_format = 3'b000;
    logic [31:0]   req_address = 32'h0;
    logic [31:0]   req_wdata = 32'h0;
    logic          resp_valid;
    logic          resp_error;
    logic [31:0]   resp_rdata;
    logic [AW-1:0] mem_address;
    logic [3:0]    mem_byteena;
    logic [31:0]   mem_data;
    logic          mem_wren;
    logic [31:0]   mem_q = 32'h0;

    logic [31:0] mem [0:(1<<AW)-1];

    always #5 clock = ~clock;

    data_access_sequencer #(.ADDR_WIDTH(AW)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_format(req_format), .req_address(req_address), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_error(resp_error), .resp_rdata(resp_rdata),
        .mem_address(mem_address), .mem_byteena(mem_byteena), .mem_data(mem_data),
        .mem_wren(mem_wren), .mem_q(mem_q)
    );

    // Memory model: read returns the pre-write contents one cycle later.
    always @(posedge clock) begin
        mem_q <= mem[mem_address];
        for (int b = 0; b < 4; b++)
            if (mem_wren && mem_byteena[b]) mem[mem_address][8*b +: 8] = mem_data[8*b +: 8];
    end

    int cyc = 0, mc_cnt = 0, wr_cnt = 0, resp_cnt = 0, acc_cnt = 0;
    logic [3:0]    log_be   [0:255];
    logic [31:0]   log_data [0:255];
    logic [AW-1:0] log_addr [0:255];
    int            acc_cyc  [0:15];

    always @(posedge clock) begin
        if (mem_byteena != 4'b0000) begin
            log_be[mc_cnt % 256]   = mem_byteena;
            log_data[mc_cnt % 256] = mem_data;
            log_addr[mc_cnt % 256] = mem_address;
            mc_cnt++;
        end
        if (mem_wren) wr_cnt++;
        if (resp_valid) resp_cnt++;
        if (req_valid && req_ready) begin
            acc_cyc[acc_cnt % 16] = cyc;
            acc_cnt++;
        end
        cyc++;
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    endtask

    task automatic do_req(input logic w, input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] d, output int lat, output logic err,
                          output logic [31:0] rd);
        int guard = 0;
        while (!req_ready && guard < 20) begin
            @(posedge clock); #1; guard++;
        end
        if (!req_ready) check_eq("ready_wait", {31'b0, req_ready}, 32'h1);
        req_write = w; req_format = f; req_address = a; req_wdata = d; req_valid = 1'b1;
        @(posedge clock); #1;
        req_valid = 1'b0;
        lat = 1;
        while (!resp_valid && lat < 12) begin
            @(posedge clock); #1; lat++;
        end
        err = resp_error;
        rd  = resp_rdata;
    endtask

    task automatic run_load(input string tag, input logic [2:0] f, input logic [31:0] a,
                            input int exp_lat, input logic exp_err, input logic [31:0] exp_rd);
        int lat, mc0, wr0;
        logic err;
        logic [31:0] rd;
        mc0 = mc_cnt; wr0 = wr_cnt;
        do_req(1'b0, f, a, 32'h0, lat, err, rd);
        check_eq({tag, ".lat"},   lat, exp_lat);
        check_eq({tag, ".err"},   {31'b0, err}, {31'b0, exp_err});
        check_eq({tag, ".rdata"}, rd, exp_rd);
        check_eq({tag, ".memcyc"}, mc_cnt - mc0, exp_err ? 0 : exp_lat - 1);
        check_eq({tag, ".wren"},  wr_cnt - wr0, 0);
        $display("load  %-10s addr=0x%08h fmt=%0d lat=%0d err=%0d rdata=0x%08h", tag, a, f, lat, err, rd);
    endtask

    task automatic run_store(input string tag, input logic [2:0] f, input logic [31:0] a,
                             input logic [31:0] d, input int exp_lat, input logic exp_err,
                             output int mc0);
        int lat, wr0;
        logic err;
        logic [31:0] rd;
        mc0 = mc_cnt; wr0 = wr_cnt;
        do_req(1'b1, f, a, d, lat, err, rd);
        check_eq({tag, ".lat"},   lat, exp_lat);
        check_eq({tag, ".err"},   {31'b0, err}, {31'b0, exp_err});
        check_eq({tag, ".rdata"}, rd, 32'h0);
        check_eq({tag, ".wren"},  wr_cnt - wr0, exp_err ? 0 : exp_lat - 1);
        $display("store %-10s addr=0x%08h fmt=%0d data=0x%08h lat=%0d err=%0d", tag, a, f, d, lat, err);
    endtask

    initial begin
        for (int i = 0; i < (1 << AW); i++) mem[i] = 32'h0;
        mem[15'h4000] = 32'h4433_2211;
        mem[15'h4001] = 32'h8877_6655;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        int mc0, a0, rcount, rs0;
        logic [31:0] rlist [0:1];
        logic [31:0] st_addr;

        // Reset behaviour, including a request presented while reset is high.
        req_valid = 1'b1; req_format = {1'b0, FMT_WORD}; req_address = 32'h1001_0000;
        repeat (3) @(posedge clock);
        #1;
        check_eq("rst.ready", {31'b0, req_ready}, 32'h0);
        check_eq("rst.resp",  {31'b0, resp_valid}, 32'h0);
        check_eq("rst.wren",  {31'b0, mem_wren}, 32'h0);
        check_eq("rst.be",    {28'b0, mem_byteena}, 32'h0);
        req_valid = 1'b0;
        reset = 1'b0;
        #1;
        check_eq("rst.ready_after", {31'b0, req_ready}, 32'h1);
        $display("reset released, req_ready=%0d", req_ready);
        @(posedge clock); #1;

        // Aligned and non-crossing loads.
        mc0 = mc_cnt;
        run_load("lw0", {1'b0, FMT_WORD}, 32'h1001_0000, 2, 1'b0, 32'h4433_2211);
        check_eq("lw0.be",   {28'b0, log_be[mc0 % 256]}, 32'hF);
        check_eq("lw0.addr", {17'b0, log_addr[mc0 % 256]}, 32'h4000);
        run_load("lb7",  {1'b0, FMT_BYTE}, 32'h1001_0007, 2, 1'b0, 32'hFFFF_FF88);
        run_load("lbu7", {1'b1, FMT_BYTE}, 32'h1001_0007, 2, 1'b0, 32'h0000_0088);
        run_load("lh1",  {1'b0, FMT_HALF}, 32'h1001_0001, 2, 1'b0, 32'h0000_3322);
        run_load("lh6",  {1'b0, FMT_HALF}, 32'h1001_0006, 2, 1'b0, 32'hFFFF_8877);
        run_load("lhu6", {1'b1, FMT_HALF}, 32'h1001_0006, 2, 1'b0, 32'h0000_8877);

        // Word-straddling loads.
`ifdef DATA_MISALIGNED_SPLIT_EN
        mc0 = mc_cnt;
        run_load("lh3x", {1'b0, FMT_HALF}, 32'h1001_0003, 3, 1'b0, 32'h0000_5544);
        check_eq("lh3x.be_lo",   {28'b0, log_be[mc0 % 256]}, 32'h8);
        check_eq("lh3x.addr_lo", {17'b0, log_addr[mc0 % 256]}, 32'h4000);
        check_eq("lh3x.be_hi",   {28'b0, log_be[(mc0 + 1) % 256]}, 32'h1);
        check_eq("lh3x.addr_hi", {17'b0, log_addr[(mc0 + 1) % 256]}, 32'h4001);
        run_load("lw1x", {1'b0, FMT_WORD}, 32'h1001_0001, 3, 1'b0, 32'h5544_3322);
`else
        run_load("lh3x", {1'b0, FMT_HALF}, 32'h1001_0003, 1, 1'b1, 32'h0);
        run_load("lw1x", {1'b0, FMT_WORD}, 32'h1001_0001, 1, 1'b1, 32'h0);
`endif

        // Address range and format faults, plus the legal edges of the window.
        run_load("below",   {1'b0, FMT_WORD},    32'h1000_0000, 1, 1'b1, 32'h0);
        run_load("pastend", {1'b0, FMT_WORD},    32'h1001_FFFE, 1, 1'b1, 32'h0);
        run_load("fmt11",   {1'b0, FMT_ILLEGAL}, 32'h1001_0000, 1, 1'b1, 32'h0);
        run_load("wrap",    {1'b0, FMT_HALF},    32'hFFFF_FFFF, 1, 1'b1, 32'h0);
        run_load("lastb",   {1'b0, FMT_BYTE},    32'h1001_FFFF, 2, 1'b0, 32'h0);
        run_load("lastw",   {1'b0, FMT_WORD},    32'h1001_FFFC, 2, 1'b0, 32'h0);

        // Back-to-back requests with req_valid held high.
        @(posedge clock); #1;
        a0 = acc_cnt; rcount = 0;
        req_write = 1'b0; req_format = {1'b0, FMT_WORD}; req_address = 32'h1001_0000; req_valid = 1'b1;
        @(posedge clock); #1;
        req_format = {1'b0, FMT_BYTE}; req_address = 32'h1001_0007;
        for (int k = 0; k < 12 && rcount < 2; k++) begin
            @(posedge clock); #1;
            if (acc_cnt >= a0 + 2) req_valid = 1'b0;
            if (resp_valid) begin
                rlist[rcount] = resp_rdata;
                rcount++;
            end
        end
        req_valid = 1'b0;
        check_eq("b2b.accepts", acc_cnt - a0, 2);
        check_eq("b2b.gap", acc_cyc[(a0 + 1) % 16] - acc_cyc[a0 % 16], 3);
        check_eq("b2b.resps", rcount, 2);
        if (rcount == 2) begin
            check_eq("b2b.rd0", rlist[0], 32'h4433_2211);
            check_eq("b2b.rd1", rlist[1], 32'hFFFF_FF88);
        end
        $display("b2b   accepts=%0d responses=%0d", acc_cnt - a0, rcount);

        // Aligned and misaligned non-crossing stores.
        run_store("sw8", {1'b0, FMT_WORD}, 32'h1001_0008, 32'hCAFE_F00D, 2, 1'b0, mc0);
        check_eq("sw8.be",   {28'b0, log_be[mc0 % 256]}, 32'hF);
        check_eq("sw8.data", log_data[mc0 % 256], 32'hCAFE_F00D);
        check_eq("sw8.mem",  mem[15'h4002], 32'hCAFE_F00D);
        run_store("sbB", {1'b0, FMT_BYTE}, 32'h1001_000B, 32'h0000_005A, 2, 1'b0, mc0);
        check_eq("sbB.be",   {28'b0, log_be[mc0 % 256]}, 32'h8);
        check_eq("sbB.data", log_data[mc0 % 256], 32'h5A00_0000);
        check_eq("sbB.mem",  mem[15'h4002], 32'h5AFE_F00D);
        run_store("shD", {1'b0, FMT_HALF}, 32'h1001_000D, 32'h1234_BEEF, 2, 1'b0, mc0);
        check_eq("shD.be",   {28'b0, log_be[mc0 % 256]}, 32'h6);
        check_eq("shD.data", log_data[mc0 % 256], 32'h34BE_EF00);
        check_eq("shD.mem",  mem[15'h4003], 32'h00BE_EF00);
        run_load("lhD",  {1'b0, FMT_HALF}, 32'h1001_000D, 2, 1'b0, 32'hFFFF_BEEF);
        run_load("lhuD", {1'b1, FMT_HALF}, 32'h1001_000D, 2, 1'b0, 32'h0000_BEEF);

        // Crossing store.
`ifdef DATA_MISALIGNED_SPLIT_EN
        run_store("sw2x", {1'b0, FMT_WORD}, 32'h1001_0002, 32'hAABB_CCDD, 3, 1'b0, mc0);
        check_eq("sw2x.be_lo",   {28'b0, log_be[mc0 % 256]}, 32'hC);
        check_eq("sw2x.data_lo", log_data[mc0 % 256], 32'hCCDD_0000);
        check_eq("sw2x.be_hi",   {28'b0, log_be[(mc0 + 1) % 256]}, 32'h3);
        check_eq("sw2x.data_hi", log_data[(mc0 + 1) % 256], 32'h0000_AABB);
        check_eq("sw2x.mem0", mem[15'h4000], 32'hCCDD_2211);
        check_eq("sw2x.mem1", mem[15'h4001], 32'h8877_AABB);
        run_load("rb0", {1'b0, FMT_WORD}, 32'h1001_0000, 2, 1'b0, 32'hCCDD_2211);
`else
        run_store("sw2x", {1'b0, FMT_WORD}, 32'h1001_0002, 32'hAABB_CCDD, 1, 1'b1, mc0);
        check_eq("sw2x.memcyc", mc_cnt - mc0, 0);
        check_eq("sw2x.mem0", mem[15'h4000], 32'h4433_2211);
        check_eq("sw2x.mem1", mem[15'h4001], 32'h8877_6655);
`endif

        // Reset in the middle of a store: it is abandoned and never answered.
`ifdef DATA_MISALIGNED_SPLIT_EN
        st_addr = 32'h1001_000E;
`else
        st_addr = 32'h1001_0010;
`endif
        @(posedge clock); #1;
        rs0 = resp_cnt;
        req_write = 1'b1; req_format = {1'b0, FMT_WORD}; req_address = st_addr;
        req_wdata = 32'h1122_3344; req_valid = 1'b1;
        @(posedge clock); #1;
        req_valid = 1'b0;
`ifdef DATA_MISALIGNED_SPLIT_EN
        @(posedge clock); #1;
`endif
        check_eq("midrst.wren_pre", {31'b0, mem_wren}, 32'h1);
        reset = 1'b1;
        #1;
        check_eq("midrst.wren",  {31'b0, mem_wren}, 32'h0);
        check_eq("midrst.be",    {28'b0, mem_byteena}, 32'h0);
        check_eq("midrst.ready", {31'b0, req_ready}, 32'h0);
        @(posedge clock); #1;
        reset = 1'b0;
        #1;
        check_eq("midrst.idle", {31'b0, req_ready}, 32'h1);
        @(posedge clock); #1;
        @(posedge clock); #1;
        check_eq("midrst.noresp", resp_cnt - rs0, 0);
`ifdef DATA_MISALIGNED_SPLIT_EN
        check_eq("midrst.mem_lo", mem[15'h4003], 32'h3344_EF00);
        check_eq("midrst.mem_hi", mem[15'h4004], 32'h0);
`else
        check_eq("midrst.mem", mem[15'h4004], 32'h0);
`endif
        $display("midrst addr=0x%08h responses=%0d", st_addr, resp_cnt - rs0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
